// File: rtl/rr_mux_arb.sv
// N-channel registered selector: fixed-select or round-robin arbitration into a
// one-deep valid/ready output register, with a transfer counter.
module rr_mux_arb #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        xfer_cnt
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] gnt_ch;
  logic             gnt_vld;
  logic             load_en;
  logic             xfer;

  assign load_en = !out_valid || out_ready;

  always_comb begin
    int idx;
    gnt_ch  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (!mode) begin
      // out-of-range select must not index in_valid
      if ({{(32-SEL_W){1'b0}}, select} < NUM_CH) begin
        gnt_ch  = select;
        gnt_vld = in_valid[select];
      end
    end else begin
      // scan from farthest to nearest so the nearest valid channel after rr_ptr wins
      for (int off = NUM_CH; off >= 1; off--) begin
        idx = (int'(rr_ptr) + off) % NUM_CH;
        if (in_valid[idx]) begin
          gnt_ch  = SEL_W'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign xfer = gnt_vld && load_en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_rdy
    assign in_ready[i] = xfer && (gnt_ch == SEL_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      xfer_cnt  <= '0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      out_data  <= in_data[gnt_ch*WIDTH +: WIDTH];
      out_ch    <= gnt_ch;
      out_valid <= 1'b1;
      rr_ptr    <= gnt_ch;
      xfer_cnt  <= xfer_cnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed self-checking bench for rr_mux_arb (8 channels x 32 bits).
module tb_rr_mux_arb;

  logic              clk;
  logic              rst_n;
  logic              mode;
  logic [2:0]        select;
  logic [7:0][31:0]  ch_data;
  logic [255:0]      in_data;
  logic [7:0]        in_valid;
  logic [7:0]        in_ready;
  logic [31:0]       out_data;
  logic [2:0]        out_ch;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       xfer_cnt;

  int tests = 0;
  int fails = 0;

  assign in_data = ch_data;

  rr_mux_arb #(.WIDTH(32), .NUM_CH(8), .SEL_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; select = '0; ch_data = '0;
    in_valid = '0; out_ready = 1'b0;
    #12;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 3'd0 || xfer_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset: valid=%b data=%h ch=%0d cnt=%0d, want 0/0/0/0",
               out_valid, out_data, out_ch, xfer_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed_max();
    mode = 1'b0; select = 3'd7; ch_data[7] = 32'hFFFF_FFFF;
    in_valid = 8'h80; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 8'h80) begin
      fails++; $display("FAIL fixed_ready: got %h want 80", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFF || out_ch !== 3'd7 || xfer_cnt !== 16'd1) begin
      fails++;
      $display("FAIL fixed_load: valid=%b data=%h ch=%0d cnt=%0d, want 1/ffffffff/7/1",
               out_valid, out_data, out_ch, xfer_cnt);
    end
  endtask

  task automatic test_fixed_invalid();
    select = 3'd2; in_valid = 8'hFB;
    #1;
    tests++;
    if (in_ready !== 8'h00) begin
      fails++; $display("FAIL fixed_noval_ready: got %h want 00", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || xfer_cnt !== 16'd1 || out_data !== 32'hFFFF_FFFF || out_ch !== 3'd7) begin
      fails++;
      $display("FAIL fixed_drain: valid=%b cnt=%0d data=%h ch=%0d, want 0/1/ffffffff/7",
               out_valid, xfer_cnt, out_data, out_ch);
    end
  endtask

  task automatic test_rr_all();
    logic [2:0] exp;
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'hFF;
    for (int i = 0; i < 8; i++) ch_data[i] = 32'h1000_0000 + i;
    for (int k = 0; k < 10; k++) begin
      exp = 3'(k % 8);
      tick();
      tests++;
      if (out_ch !== exp || out_data !== 32'h1000_0000 + 32'(exp) || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL rr_all[%0d]: ch=%0d data=%h valid=%b, want %0d/%h/1",
                 k, out_ch, out_data, out_valid, exp, 32'h1000_0000 + 32'(exp));
      end
    end
    tests++;
    if (xfer_cnt !== 16'd10) begin
      fails++; $display("FAIL rr_all_cnt: got %0d want 10", xfer_cnt);
    end
  endtask

  task automatic test_rr_two();
    logic [2:0] exp;
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'h22;
    ch_data[1] = 32'hCAFE_0001; ch_data[5] = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      exp = (k % 2 == 0) ? 3'd1 : 3'd5;
      tick();
      tests++;
      if (out_ch !== exp || out_data !== ((exp == 3'd1) ? 32'hCAFE_0001 : 32'h1234_5678)) begin
        fails++;
        $display("FAIL rr_two[%0d]: ch=%0d data=%h, want ch %0d", k, out_ch, out_data, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; select = 3'd0; ch_data[0] = 32'h0000_0001;
    in_valid = 8'h01; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; select = 3'd4; ch_data[4] = 32'hAAAA_0004; in_valid = 8'h10;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (in_ready !== 8'h00) begin
        fails++; $display("FAIL stall_ready[%0d]: got %h want 00", k, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'h1 || out_ch !== 3'd0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h ch=%0d, want 1/00000001/0",
                 k, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 8'h10) begin
      fails++; $display("FAIL release_ready: got %h want 10", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hAAAA_0004 || out_ch !== 3'd4 || xfer_cnt !== 16'd2) begin
      fails++;
      $display("FAIL release_load: valid=%b data=%h ch=%0d cnt=%0d, want 1/aaaa0004/4/2",
               out_valid, out_data, out_ch, xfer_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    // beat from ch4 is still held; stall it, then reset between edges
    out_ready = 1'b0; in_valid = 8'hFF; mode = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || xfer_cnt !== 16'd0 || out_ch !== 3'd0) begin
      fails++;
      $display("FAIL async_reset: valid=%b data=%h cnt=%0d ch=%0d, want 0/0/0/0",
               out_valid, out_data, xfer_cnt, out_ch);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) ch_data[i] = 32'h5000_0000 + i;
    #1;
    tests++;
    if (in_ready !== 8'h01) begin
      fails++; $display("FAIL post_reset_ready: got %h want 01", in_ready);
    end
    tick();
    tests++;
    if (out_ch !== 3'd0 || out_data !== 32'h5000_0000 || xfer_cnt !== 16'd1) begin
      fails++;
      $display("FAIL post_reset_grant: ch=%0d data=%h cnt=%0d, want 0/50000000/1",
               out_ch, out_data, xfer_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_max();
    test_fixed_invalid();
    test_rr_all();
    test_rr_two();
    test_backpressure();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-channel, W-bit registered selector; successor to the 8:1 32-bit combinational mux in the ALU datapath.
- Two modes:
  - Fixed mode: the select input picks the channel.
  - Round-robin mode: the block arbitrates fairly among valid channels.
- The chosen channel is loaded into a one-deep output register with a valid/ready handshake.
- Sits between ALU result sources and the result writeback stage.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_CH, 8, number of input channels (2..16).
- SEL_W, 3, width of select/channel index; must equal ceil(log2(NUM_CH)).
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- select  input  SEL_W  channel index used in fixed mode.
- in_data  input  NUM_CH*WIDTH  flat bus; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (one-hot or zero).
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  out_data holds an unconsumed beat.
- out_ready  input  1  downstream accepts the beat.
- xfer_cnt  output  CNT_W  count of beats accepted from inputs.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, xfer_cnt=0, rr_ptr=NUM_CH-1. Reset mid-operation discards the held beat immediately.
- Load enable: load_en = !out_valid || out_ready. This allows a full-throughput pass-through: one beat per cycle when out_ready is held high.
- Fixed mode (mode=0):
  - Candidate channel = select.
  - Grant only if in_valid[select]=1; otherwise no grant.
  - select >= NUM_CH means no grant.
- Round-robin mode (mode=1):
  - Scan channels starting at (rr_ptr+1) mod NUM_CH and wrap around.
  - The first channel with in_valid=1 is granted.
  - No valid channels means no grant.
- in_ready[g] = load_en && grant_valid, for granted channel g only; all other bits 0. in_ready is combinational from in_valid, mode, select, out_valid, out_ready and rr_ptr.
- Transfer occurs when in_valid[g] && in_ready[g]. On a transfer, at the next edge:
  - out_data <= channel g data, out_ch <= g, out_valid <= 1.
  - rr_ptr <= g (updated in both modes).
  - xfer_cnt <= xfer_cnt+1, wrapping at 2^CNT_W to 0.
- No transfer while out_ready=1 and out_valid=1: out_valid <= 0 at the next edge; out_data and out_ch hold their last values.
- Stall (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold; all in_ready=0; rr_ptr holds.
- Simultaneous consume and load: the old beat leaves and the new beat enters on the same edge; out_valid stays 1.
- Latency: 1 cycle from input acceptance to out_valid.
- Mode or select changes take effect on the next arbitration only and never alter a held beat.
- Inputs must hold in_valid and data until accepted. The block does not require this for correctness, since no state is captured without a transfer.

Test Plan:
- Reset, then fixed mode, select=3'b111, ch7=32'hFFFFFFFF valid, out_ready=1 -> in_ready=8'h80 same cycle; next cycle out_valid=1, out_data=32'hFFFFFFFF, out_ch=7, xfer_cnt=1.
- Fixed mode, select=2, in_valid[2]=0 and all other channels valid -> in_ready=0, out_valid drops to 0 after one cycle, xfer_cnt unchanged.
- Round-robin mode, all 8 valid, ch i data = 32'h10000000+i, out_ready=1 for 10 cycles -> out_ch sequence 0,1,...,7,0,1; xfer_cnt=10.
- Round-robin mode, only ch1 and ch5 valid, ch5=32'h12345678 -> grants alternate 1,5,1,5; after a grant to 5 the next grant is 1 (wrap-around).
- Backpressure: beat loaded (out_data=32'h00000001), then out_ready=0 for 3 cycles with ch4 valid -> in_ready=0, out_data/out_ch stable, out_valid=1. Then out_ready=1 -> ch4 loaded on the same edge the old beat is consumed.
- rst_n pulsed low mid-stall (asynchronous, between edges) -> out_valid=0, out_data=0, xfer_cnt=0 immediately. After release, round-robin first grant goes to ch0 when all are valid.
